bitslice_alu_n: RTL and testbench

Parametrised successor to the 4-bit Am2901 slice. It is a WIDTH-bit microprogrammed ALU slice with an NREGS-entry two-port register file, a Q register, and up/down shift networks. It keeps the same 9-bit instruction encoding (source/function/destination) and adds a synchronous reset, a clock enable, and a registered status word. It sits under controller.v as the datapath; multiple instances chain through cin/cout or g_lo/p_lo.

---
 rtl/bitslice_pkg.sv | 41 ++++
 rtl/bitslice_regfile.sv | 42 ++++
 rtl/bitslice_alu_n.sv | 154 +++++++++++++++
 tb/tb_bitslice_alu_n.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bitslice_pkg.sv
// Shared encodings for the bitslice ALU: source, function and destination fields
// of the 9-bit microinstruction, plus bit positions inside the status word.
package bitslice_pkg;

  localparam logic [2:0] SRC_AQ = 3'd0;
  localparam logic [2:0] SRC_AB = 3'd1;
  localparam logic [2:0] SRC_ZQ = 3'd2;
  localparam logic [2:0] SRC_ZB = 3'd3;
  localparam logic [2:0] SRC_ZA = 3'd4;
  localparam logic [2:0] SRC_DA = 3'd5;
  localparam logic [2:0] SRC_DQ = 3'd6;
  localparam logic [2:0] SRC_D0 = 3'd7;

  localparam logic [2:0] FN_ADD   = 3'd0;
  localparam logic [2:0] FN_SUBR  = 3'd1;
  localparam logic [2:0] FN_SUBS  = 3'd2;
  localparam logic [2:0] FN_OR    = 3'd3;
  localparam logic [2:0] FN_AND   = 3'd4;
  localparam logic [2:0] FN_NOTRS = 3'd5;
  localparam logic [2:0] FN_EXOR  = 3'd6;
  localparam logic [2:0] FN_EXNOR = 3'd7;

  localparam logic [2:0] DST_QREG  = 3'd0;
  localparam logic [2:0] DST_NOP   = 3'd1;
  localparam logic [2:0] DST_RAMA  = 3'd2;
  localparam logic [2:0] DST_RAMF  = 3'd3;
  localparam logic [2:0] DST_RAMQD = 3'd4;
  localparam logic [2:0] DST_RAMD  = 3'd5;
  localparam logic [2:0] DST_RAMQU = 3'd6;
  localparam logic [2:0] DST_RAMU  = 3'd7;

  localparam int ST_FMSB = 0;
  localparam int ST_COUT = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_Z    = 3;

  function automatic logic is_arith(input logic [2:0] fn);
    return (fn <= FN_SUBS);
  endfunction

endpackage

// File: rtl/bitslice_regfile.sv
// Two-read, one-write register file for the bitslice ALU. With RF_CLEAR_EN
// defined, clear wipes every entry on the same edge; otherwise clear is ignored.
module bitslice_regfile #(
  parameter int WIDTH = 8,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    a_addr,
  input  logic [AW-1:0]    b_addr,
  output logic [WIDTH-1:0] a_data,
  output logic [WIDTH-1:0] b_data
);

  logic [WIDTH-1:0] mem [NREGS];

`ifdef RF_CLEAR_EN
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int k = 0; k < NREGS; k++) mem[k] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  logic unused_clear;
  assign unused_clear = clear;
`endif

  // No write-through: a write becomes visible on the next cycle.
  assign a_data = mem[a_addr];
  assign b_data = mem[b_addr];

endmodule

// File: rtl/bitslice_alu_n.sv
// WIDTH-bit microprogrammed ALU slice (Am2901 instruction set) with Q register,
// shift networks, clock enable and registered status. RF_CLEAR_EN: rst clears the RF.
module bitslice_alu_n
  import bitslice_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             cp,
  input  logic             rst,
  input  logic             ce,
  input  logic [8:0]       i,
  input  logic             cin,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    a,
  input  logic [AW-1:0]    b,
  input  logic             oe,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             g_lo,
  output logic             p_lo,
  output logic             ovr,
  output logic             z,
  output logic             fmsb,
  input  logic             ram_lsb_in,
  input  logic             ram_msb_in,
  output logic             ram_lsb_out,
  output logic             ram_msb_out,
  input  logic             q_lsb_in,
  input  logic             q_msb_in,
  output logic             q_lsb_out,
  output logic             q_msb_out,
  input  logic             flag_we,
  output logic [3:0]       status
);

  logic [2:0]       src, fn, dst;
  logic [WIDTH-1:0] a_data, b_data, q, r_op, s_op, x_op, y_op, f, y_int, rf_wdata;
  logic [WIDTH:0]   sum;
  logic             arith, c_msb, gg, rf_we_op, rf_we;

  assign src = i[2:0];
  assign fn  = i[5:3];
  assign dst = i[8:6];

  bitslice_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_rf (
    .clk   (cp),
    .clear (rst),
    .we    (rf_we),
    .waddr (b),
    .wdata (rf_wdata),
    .a_addr(a),
    .b_addr(b),
    .a_data(a_data),
    .b_data(b_data)
  );

  always_comb begin
    r_op = '0;
    s_op = '0;
    case (src)
      SRC_AQ:  begin r_op = a_data; s_op = q;      end
      SRC_AB:  begin r_op = a_data; s_op = b_data; end
      SRC_ZQ:  s_op = q;
      SRC_ZB:  s_op = b_data;
      SRC_ZA:  s_op = a_data;
      SRC_DA:  begin r_op = d; s_op = a_data; end
      SRC_DQ:  begin r_op = d; s_op = q;      end
      default: r_op = d;
    endcase
  end

  // Subtraction inverts one operand; the adder and lookahead see the inverted one.
  always_comb begin
    x_op = r_op;
    y_op = s_op;
    if (fn == FN_SUBR)      x_op = ~r_op;
    else if (fn == FN_SUBS) y_op = ~s_op;
  end

  assign sum   = {1'b0, x_op} + {1'b0, y_op} + {{WIDTH{1'b0}}, cin};
  assign arith = is_arith(fn);
  assign c_msb = x_op[WIDTH-1] ^ y_op[WIDTH-1] ^ sum[WIDTH-1];

  always_comb begin
    gg = 1'b0;
    for (int k = 0; k < WIDTH; k++) gg = (x_op[k] & y_op[k]) | ((x_op[k] | y_op[k]) & gg);
  end

  always_comb begin
    case (fn)
      FN_OR:    f = r_op | s_op;
      FN_AND:   f = r_op & s_op;
      FN_NOTRS: f = ~r_op & s_op;
      FN_EXOR:  f = r_op ^ s_op;
      FN_EXNOR: f = ~(r_op ^ s_op);
      default:  f = sum[WIDTH-1:0];
    endcase
  end

  assign cout = arith & sum[WIDTH];
  assign ovr  = arith & (c_msb ^ sum[WIDTH]);
  assign g_lo = ~(arith & gg);
  assign p_lo = ~(arith & (&(x_op | y_op)));
  assign z    = (f == '0);
  assign fmsb = f[WIDTH-1];

  assign ram_lsb_out = ((dst == DST_RAMQD) || (dst == DST_RAMD)) & f[0];
  assign ram_msb_out = ((dst == DST_RAMQU) || (dst == DST_RAMU)) & f[WIDTH-1];
  assign q_lsb_out   = (dst == DST_RAMQD) & q[0];
  assign q_msb_out   = (dst == DST_RAMQU) & q[WIDTH-1];

  always_comb begin
    rf_we_op = 1'b0;
    rf_wdata = f;
    case (dst)
      DST_RAMA, DST_RAMF:  rf_we_op = 1'b1;
      DST_RAMQD, DST_RAMD: begin rf_we_op = 1'b1; rf_wdata = {ram_msb_in, f[WIDTH-1:1]}; end
      DST_RAMQU, DST_RAMU: begin rf_we_op = 1'b1; rf_wdata = {f[WIDTH-2:0], ram_lsb_in}; end
      default: ;
    endcase
  end

  assign rf_we = ce & ~rst & rf_we_op;

  always_ff @(posedge cp) begin
    if (rst) begin
      q <= '0;
    end else if (ce) begin
      case (dst)
        DST_QREG:  q <= f;
        DST_RAMQD: q <= {q_msb_in, q[WIDTH-1:1]};
        DST_RAMQU: q <= {q[WIDTH-2:0], q_lsb_in};
        default: ;
      endcase
    end
  end

  always_ff @(posedge cp) begin
    if (rst) begin
      status <= '0;
    end else if (ce && flag_we) begin
      status[ST_Z]    <= z;
      status[ST_OVR]  <= ovr;
      status[ST_COUT] <= cout;
      status[ST_FMSB] <= fmsb;
    end
  end

  assign y_int = (dst == DST_RAMA) ? a_data : f;
  assign y     = oe ? {WIDTH{1'bz}} : y_int;

endmodule

// File: tb/tb_bitslice_alu_n.sv
// Directed bench for bitslice_alu_n (WIDTH=8, NREGS=16); driver queues expectations
// per cycle and a negedge monitor compares them. Honors RF_CLEAR_EN when defined.
module tb_bitslice_alu_n;
  import bitslice_pkg::*;

  localparam int W  = 8;
  localparam int NR = 16;
  localparam int AWL = 4;

  localparam int FLD_Y = 0, FLD_Z = 1, FLD_OVR = 2, FLD_COUT = 3, FLD_FMSB = 4,
                 FLD_GLO = 5, FLD_PLO = 6, FLD_STATUS = 7, FLD_RLSB = 8, FLD_RMSB = 9,
                 FLD_QLSB = 10, FLD_QMSB = 11, FLD_YOFF = 12;

`ifdef RF_CLEAR_EN
  localparam logic [W-1:0] RST_V = 8'h3C;
  localparam logic [W-1:0] R4_AFTER = 8'h00;
`else
  localparam logic [W-1:0] RST_V = 8'h00;
  localparam logic [W-1:0] R4_AFTER = 8'h66;
`endif

  logic cp = 1'b0;
  logic rst, ce, cin, oe, flag_we, ram_lsb_in, ram_msb_in, q_lsb_in, q_msb_in;
  logic [8:0] i;
  logic [W-1:0] d;
  logic [AWL-1:0] a, b;
  wire  [W-1:0] y;
  logic cout, g_lo, p_lo, ovr, z, fmsb, ram_lsb_out, ram_msb_out, q_lsb_out, q_msb_out;
  logic [3:0] status;

  bitslice_alu_n #(.WIDTH(W), .NREGS(NR)) dut (
    .cp(cp), .rst(rst), .ce(ce), .i(i), .cin(cin), .d(d), .a(a), .b(b), .oe(oe),
    .y(y), .cout(cout), .g_lo(g_lo), .p_lo(p_lo), .ovr(ovr), .z(z), .fmsb(fmsb),
    .ram_lsb_in(ram_lsb_in), .ram_msb_in(ram_msb_in),
    .ram_lsb_out(ram_lsb_out), .ram_msb_out(ram_msb_out),
    .q_lsb_in(q_lsb_in), .q_msb_in(q_msb_in),
    .q_lsb_out(q_lsb_out), .q_msb_out(q_msb_out),
    .flag_we(flag_we), .status(status)
  );

  // clock / cycle counter
  always #5 cp = ~cp;
  int cyc_n = 0;
  always @(posedge cp) cyc_n++;

  typedef struct {
    int          cyc;
    int          fld;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  function automatic string fld_name(input int f);
    case (f)
      FLD_Y: return "y";         FLD_Z: return "z";         FLD_OVR: return "ovr";
      FLD_COUT: return "cout";   FLD_FMSB: return "fmsb";   FLD_GLO: return "g_lo";
      FLD_PLO: return "p_lo";    FLD_STATUS: return "status"; FLD_RLSB: return "ram_lsb_out";
      FLD_RMSB: return "ram_msb_out"; FLD_QLSB: return "q_lsb_out"; FLD_QMSB: return "q_msb_out";
      default: return "y_hiz";
    endcase
  endfunction

  function automatic logic [31:0] act(input int f);
    case (f)
      FLD_Y, FLD_YOFF: return {24'b0, y};
      FLD_Z: return {31'b0, z};
      FLD_OVR: return {31'b0, ovr};
      FLD_COUT: return {31'b0, cout};
      FLD_FMSB: return {31'b0, fmsb};
      FLD_GLO: return {31'b0, g_lo};
      FLD_PLO: return {31'b0, p_lo};
      FLD_STATUS: return {28'b0, status};
      FLD_RLSB: return {31'b0, ram_lsb_out};
      FLD_RMSB: return {31'b0, ram_msb_out};
      FLD_QLSB: return {31'b0, q_lsb_out};
      default: return {31'b0, q_msb_out};
    endcase
  endfunction

  // scoreboard monitor
  always @(negedge cp) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_n) begin
      e = exp_q.pop_front();
      checks++;
      if (e.cyc != cyc_n) begin
        errors++;
        $display("FAIL %s: expectation from cycle %0d reached monitor at cycle %0d",
                 fld_name(e.fld), e.cyc, cyc_n);
      end else if (e.fld == FLD_YOFF) begin
        if (y === e.val[W-1:0]) begin
          errors++;
          $display("FAIL y_hiz @%0d: got %h, must not drive %h", cyc_n, y, e.val[W-1:0]);
        end
      end else if (act(e.fld) !== e.val) begin
        errors++;
        $display("FAIL %s @%0d: got %h, expected %h", fld_name(e.fld), cyc_n, act(e.fld), e.val);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  task automatic expect_f(input int fld, input logic [31:0] val);
    exp_q.push_back('{cyc_n, fld, val});
  endtask

  task automatic set_op(input logic [2:0] dst, input logic [2:0] fn, input logic [2:0] src);
    i = {dst, fn, src};
  endtask

  task automatic write_reg(input logic [AWL-1:0] adr, input logic [W-1:0] v);
    set_op(DST_RAMF, FN_OR, SRC_D0);
    d = v;
    b = adr;
    flag_we = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; cin = 1'b0; oe = 1'b0; flag_we = 1'b0;
    ram_lsb_in = 1'b0; ram_msb_in = 1'b0; q_lsb_in = 1'b0; q_msb_in = 1'b0;
    set_op(DST_NOP, FN_OR, SRC_D0); d = '0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;

    // Make Q and status nonzero so reset has something to clear
    write_reg(5, RST_V);
    set_op(DST_QREG, FN_OR, SRC_D0); d = 8'h80; flag_we = 1'b1; tick();
    flag_we = 1'b0;
    set_op(DST_NOP, FN_OR, SRC_ZQ);
    expect_f(FLD_Y, 8'h80); expect_f(FLD_STATUS, 4'b0001); tick();
    rst = 1'b1; tick(); rst = 1'b0;

    set_op(DST_NOP, FN_OR, SRC_ZA); a = 5;
    expect_f(FLD_Y, 8'h00); expect_f(FLD_Z, 1); expect_f(FLD_OVR, 0); expect_f(FLD_COUT, 0);
    expect_f(FLD_FMSB, 0); expect_f(FLD_GLO, 1); expect_f(FLD_PLO, 1); expect_f(FLD_STATUS, 0);
    tick();
    set_op(DST_NOP, FN_OR, SRC_ZQ); expect_f(FLD_Y, 8'h00); tick();

    // Load, read back, clock-enable freeze
    set_op(DST_RAMF, FN_ADD, SRC_D0); d = 8'hA5; b = 3; cin = 1'b0;
    expect_f(FLD_Y, 8'hA5); expect_f(FLD_COUT, 0); tick();
    set_op(DST_NOP, FN_OR, SRC_ZA); a = 3; expect_f(FLD_Y, 8'hA5); tick();
    ce = 1'b0; flag_we = 1'b1;
    set_op(DST_RAMF, FN_ADD, SRC_D0); d = 8'h91; b = 3; expect_f(FLD_Y, 8'h91); tick();
    ce = 1'b1; flag_we = 1'b0;
    set_op(DST_NOP, FN_OR, SRC_ZA); a = 3;
    expect_f(FLD_Y, 8'hA5); expect_f(FLD_STATUS, 4'b0000); tick();

    // Overflow and carry
    write_reg(1, 8'h7F);
    set_op(DST_NOP, FN_ADD, SRC_DA); d = 8'h01; a = 1; flag_we = 1'b1;
    expect_f(FLD_Y, 8'h80); expect_f(FLD_OVR, 1); expect_f(FLD_COUT, 0);
    expect_f(FLD_FMSB, 1); expect_f(FLD_Z, 0); tick();
    expect_f(FLD_STATUS, 4'b0101);
    write_reg(1, 8'hFF);
    set_op(DST_NOP, FN_ADD, SRC_DA); d = 8'h01; a = 1; flag_we = 1'b1;
    expect_f(FLD_Y, 8'h00); expect_f(FLD_COUT, 1); expect_f(FLD_Z, 1);
    expect_f(FLD_OVR, 0); expect_f(FLD_FMSB, 0); tick();
    flag_we = 1'b0;
    set_op(DST_NOP, FN_OR, SRC_D0); d = 8'h00; expect_f(FLD_STATUS, 4'b1010); tick();

    // Shifts through RAM and Q
    write_reg(2, 8'h81);
    set_op(DST_QREG, FN_OR, SRC_D0); d = 8'h40; tick();
    set_op(DST_RAMQU, FN_OR, SRC_ZB); b = 2; ram_lsb_in = 1'b1; q_lsb_in = 1'b0;
    expect_f(FLD_Y, 8'h81); expect_f(FLD_RMSB, 1); expect_f(FLD_QMSB, 0);
    expect_f(FLD_RLSB, 0); expect_f(FLD_QLSB, 0); tick();
    set_op(DST_NOP, FN_OR, SRC_ZB); expect_f(FLD_Y, 8'h03); tick();
    set_op(DST_NOP, FN_OR, SRC_ZQ); expect_f(FLD_Y, 8'h80); tick();
    set_op(DST_RAMQD, FN_OR, SRC_ZB); ram_msb_in = 1'b0; q_msb_in = 1'b1;
    expect_f(FLD_Y, 8'h03); expect_f(FLD_RLSB, 1); expect_f(FLD_QLSB, 0);
    expect_f(FLD_RMSB, 0); expect_f(FLD_QMSB, 0); tick();
    set_op(DST_NOP, FN_OR, SRC_ZB); expect_f(FLD_Y, 8'h01); tick();
    set_op(DST_NOP, FN_OR, SRC_ZQ); expect_f(FLD_Y, 8'hC0); tick();
    set_op(DST_RAMU, FN_OR, SRC_ZQ); ram_lsb_in = 1'b0;
    expect_f(FLD_Y, 8'hC0); expect_f(FLD_RMSB, 1); expect_f(FLD_QMSB, 0); tick();
    set_op(DST_RAMA, FN_OR, SRC_D0); d = 8'h3C; a = 2; b = 6; expect_f(FLD_Y, 8'h80); tick();
    set_op(DST_NOP, FN_OR, SRC_ZA); a = 6; expect_f(FLD_Y, 8'h3C); tick();

    // Subtract, lookahead and logic functions
    write_reg(7, 8'h05);
    write_reg(8, 8'h03);
    set_op(DST_NOP, FN_SUBR, SRC_AB); a = 7; b = 8; cin = 1'b1;
    expect_f(FLD_Y, 8'hFE); expect_f(FLD_COUT, 0); expect_f(FLD_OVR, 0);
    expect_f(FLD_GLO, 1); expect_f(FLD_PLO, 1); tick();
    set_op(DST_NOP, FN_SUBS, SRC_AB);
    expect_f(FLD_Y, 8'h02); expect_f(FLD_COUT, 1); expect_f(FLD_GLO, 0); expect_f(FLD_PLO, 1); tick();
    set_op(DST_NOP, FN_AND, SRC_AB);
    expect_f(FLD_Y, 8'h01); expect_f(FLD_COUT, 0); expect_f(FLD_GLO, 1); expect_f(FLD_PLO, 1); tick();
    set_op(DST_NOP, FN_EXNOR, SRC_AB); expect_f(FLD_Y, 8'hF9); expect_f(FLD_FMSB, 1); tick();
    set_op(DST_NOP, FN_NOTRS, SRC_AB); expect_f(FLD_Y, 8'h02); tick();
    cin = 1'b0;

    // Random ADD operands against an independent adder model
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] rv, dv;
      logic cv;
      logic [W:0] s, gs;
      rv = W'($urandom_range(0, 255));
      dv = W'($urandom_range(0, 255));
      cv = 1'($urandom_range(0, 1));
      write_reg(9, rv);
      set_op(DST_NOP, FN_ADD, SRC_DA); d = dv; a = 9; cin = cv;
      s  = {1'b0, dv} + {1'b0, rv} + {8'b0, cv};
      gs = {1'b0, dv} + {1'b0, rv};
      expect_f(FLD_Y, {24'b0, s[W-1:0]});
      expect_f(FLD_COUT, {31'b0, s[W]});
      expect_f(FLD_OVR, {31'b0, (dv[W-1] == rv[W-1]) && (s[W-1] != dv[W-1])});
      expect_f(FLD_PLO, {31'b0, ~(&(dv | rv))});
      expect_f(FLD_GLO, {31'b0, ~gs[W]});
      tick();
    end
    cin = 1'b0;

    // Reset on the same edge as a write
    write_reg(4, 8'h66);
    set_op(DST_QREG, FN_OR, SRC_D0); d = 8'h81; flag_we = 1'b1; tick();
    rst = 1'b1;
    set_op(DST_RAMF, FN_OR, SRC_D0); d = 8'h55; b = 4; tick();
    rst = 1'b0; flag_we = 1'b0;
    set_op(DST_NOP, FN_OR, SRC_ZA); a = 4;
    expect_f(FLD_Y, {24'b0, R4_AFTER}); expect_f(FLD_STATUS, 4'b0000); tick();
    set_op(DST_NOP, FN_OR, SRC_ZQ); expect_f(FLD_Y, 8'h00); tick();
    oe = 1'b1;
    set_op(DST_NOP, FN_OR, SRC_D0); d = 8'h5A;
    expect_f(FLD_YOFF, 8'h5A); expect_f(FLD_Z, 0); tick();
    oe = 1'b0;

    repeat (20) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
